// File: rtl/mat_reader_pkg.sv
// Shared types and sizing for the matrix stream reader.
package mat_reader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int FIFO_DEPTH = 3;
   localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/mat_stream_reader_fifo.sv
// Small synchronous FIFO that buffers RAM read data ahead of the output stream.
module stream_fifo #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 3
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         push,
   input  logic [DATA_WIDTH-1:0]        push_data,
   input  logic                         pop,
   output logic [DATA_WIDTH-1:0]        pop_data,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic [PW-1:0]         wr_ptr_r;
   logic [PW-1:0]         rd_ptr_r;
   logic [CW-1:0]         count_r;
   logic                  do_push_s;
   logic                  do_pop_s;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) begin
         ptr_next = '0;
      end else begin
         ptr_next = p + PW'(1);
      end
   endfunction

   assign full      = (count_r == CW'(DEPTH));
   assign empty     = (count_r == CW'(0));
   assign count     = count_r;
   assign pop_data  = mem_r[rd_ptr_r];
   assign do_push_s = push && !full;
   assign do_pop_s  = pop && !empty;

   // Storage, pointers and occupancy; push and pop in one cycle leaves count unchanged.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
            wr_ptr_r        <= ptr_next(wr_ptr_r);
         end
         if (do_pop_s) begin
            rd_ptr_r <= ptr_next(rd_ptr_r);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/mat_stream_reader.sv
// Streams an R x C matrix from a 1-cycle-latency RAM in row-major or transposed order
// through a small FIFO onto a valid/ready interface.
module mat_stream_reader
   import mat_reader_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 10,
   parameter int DIM_WIDTH  = 6
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [DIM_WIDTH-1:0]  rows,
   input  logic [DIM_WIDTH-1:0]  cols,
   input  logic                  transpose,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_rd_en,
   input  logic [DATA_WIDTH-1:0] mem_rd_data,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last
);

   state_t                  state_r, state_s;
   logic [DIM_WIDTH-1:0]    rows_r, cols_r;
   logic                    transpose_r;
   logic [DIM_WIDTH-1:0]    inner_r, outer_r;
   logic [ADDR_WIDTH-1:0]   addr_r, line_base_r;
   logic                    in_flight_r, flight_last_r;

   logic [DIM_WIDTH-1:0]    inner_lim_s, outer_lim_s;
   logic [ADDR_WIDTH-1:0]   cols_ext_s, inner_step_s, outer_step_s;
   logic                    inner_end_s, final_s, zero_dim_s;
   logic [FIFO_CNT_W:0]     occ_s;
   logic                    room_s, pop_s, head_last_s;
   logic [DATA_WIDTH:0]     fifo_head_s;
   logic                    fifo_full_s, fifo_empty_s;
   logic [FIFO_CNT_W-1:0]   fifo_count_s;

   // The inner loop walks along a row (or a column when transposed); the outer loop steps lines.
   assign cols_ext_s   = ADDR_WIDTH'(cols_r);
   assign inner_step_s = transpose_r ? cols_ext_s : ADDR_WIDTH'(1);
   assign outer_step_s = transpose_r ? ADDR_WIDTH'(1) : cols_ext_s;
   assign inner_lim_s  = transpose_r ? rows_r : cols_r;
   assign outer_lim_s  = transpose_r ? cols_r : rows_r;
   assign inner_end_s  = (inner_r == inner_lim_s - DIM_WIDTH'(1));
   assign final_s      = inner_end_s && (outer_r == outer_lim_s - DIM_WIDTH'(1));
   assign zero_dim_s   = (rows == DIM_WIDTH'(0)) || (cols == DIM_WIDTH'(0));

   // Credit check uses registered state only, keeping out_ready off the read path.
   assign occ_s  = {1'b0, fifo_count_s} + {{FIFO_CNT_W{1'b0}}, in_flight_r};
   assign room_s = (occ_s < (FIFO_CNT_W + 1)'(FIFO_DEPTH));

   assign out_valid   = !fifo_empty_s;
   assign out_data    = fifo_head_s[DATA_WIDTH-1:0];
   assign out_last    = fifo_head_s[DATA_WIDTH];
   assign head_last_s = fifo_head_s[DATA_WIDTH];
   assign pop_s       = out_valid && out_ready;
   assign mem_addr    = addr_r;

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state and status/strobe decode.
   always_comb begin
      state_s   = state_r;
      busy      = 1'b0;
      done      = 1'b0;
      mem_rd_en = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               if (zero_dim_s) begin
                  state_s = DONE;
               end else begin
                  state_s = READ;
               end
            end else begin
               state_s = IDLE;
            end
         end
         READ: begin
            busy      = 1'b1;
            mem_rd_en = room_s;
            if (room_s && final_s) begin
               state_s = DRAIN;
            end else begin
               state_s = READ;
            end
         end
         DRAIN: begin
            busy = 1'b1;
            if (pop_s && head_last_s) begin
               state_s = DONE;
            end else begin
               state_s = DRAIN;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Operand capture, loop counters and incremental address accumulators.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rows_r      <= '0;
         cols_r      <= '0;
         transpose_r <= 1'b0;
         inner_r     <= '0;
         outer_r     <= '0;
         addr_r      <= '0;
         line_base_r <= '0;
      end else if (state_r == IDLE && start) begin
         rows_r      <= rows;
         cols_r      <= cols;
         transpose_r <= transpose;
         inner_r     <= '0;
         outer_r     <= '0;
         addr_r      <= base_addr;
         line_base_r <= base_addr;
      end else if (mem_rd_en) begin
         if (inner_end_s) begin
            inner_r     <= '0;
            outer_r     <= outer_r + DIM_WIDTH'(1);
            line_base_r <= line_base_r + outer_step_s;
            addr_r      <= line_base_r + outer_step_s;
         end else begin
            inner_r <= inner_r + DIM_WIDTH'(1);
            addr_r  <= addr_r + inner_step_s;
         end
      end
   end

   // Tracks the read whose data lands next cycle, tagged if it is the final element.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         in_flight_r   <= 1'b0;
         flight_last_r <= 1'b0;
      end else begin
         in_flight_r   <= mem_rd_en;
         flight_last_r <= mem_rd_en && final_s;
      end
   end

   stream_fifo #(
      .DATA_WIDTH (DATA_WIDTH + 1),
      .DEPTH      (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (in_flight_r && !fifo_full_s),
      .push_data ({flight_last_r, mem_rd_data}),
      .pop       (pop_s),
      .pop_data  (fifo_head_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s),
      .count     (fifo_count_s)
   );

endmodule

// File: tb/tb_mat_stream_reader.sv
// Scoreboard bench for mat_stream_reader: directed transfers with a RAM model where mem[a] = a.
module tb_mat_stream_reader;

   localparam int DW  = 16;
   localparam int AW  = 10;
   localparam int DMW = 6;

   logic           clock = 1'b0;
   logic           reset = 1'b1;
   logic           start = 1'b0;
   logic [AW-1:0]  base_addr = '0;
   logic [DMW-1:0] rows = '0;
   logic [DMW-1:0] cols = '0;
   logic           transpose = 1'b0;
   logic           busy, done, mem_rd_en, out_valid, out_last;
   logic [AW-1:0]  mem_addr;
   logic [DW-1:0]  mem_rd_data = '0;
   logic [DW-1:0]  out_data;
   logic           out_ready = 1'b1;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
      int            cyc;
   } exp_t;

   exp_t           exp_q[$];
   int             done_q[$];
   logic [AW-1:0]  addr_q[$];
   exp_t           e;
   int             cyc = 0;
   int             checks = 0;
   int             failures = 0;
   int             hs_cnt = 0;
   int             issued = 0;
   int             popped = 0;
   bit             no_reads = 1'b0;
   bit             prev_stall = 1'b0;
   logic [DW-1:0]  prev_data = '0;
   logic           prev_last = 1'b0;
   int             s;

   mat_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DIM_WIDTH(DMW)) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .base_addr   (base_addr),
      .rows        (rows),
      .cols        (cols),
      .transpose   (transpose),
      .busy        (busy),
      .done        (done),
      .mem_addr    (mem_addr),
      .mem_rd_en   (mem_rd_en),
      .mem_rd_data (mem_rd_data),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_last    (out_last)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   always @(posedge clock) begin
      if (mem_rd_en) mem_rd_data <= {6'd0, mem_addr};
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: pops the scoreboard on every handshake and checks protocol invariants.
   always @(negedge clock) begin
      if (reset) begin
         prev_stall = 1'b0;
         issued = 0;
         popped = 0;
      end else begin
         if (no_reads) begin
            check("zero_rd_en", 32'(mem_rd_en), 32'd0);
            check("zero_valid", 32'(out_valid), 32'd0);
         end
         if (mem_rd_en) begin
            issued++;
            check("occupancy_le3", 32'(issued - popped <= 3), 32'd1);
            if (addr_q.size() != 0) check("mem_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
         end
         if (prev_stall && out_valid) begin
            check("stall_data", 32'(out_data), 32'(prev_data));
            check("stall_last", 32'(out_last), 32'(prev_last));
         end
         if (out_valid && out_ready) begin
            hs_cnt++;
            popped++;
            if (exp_q.size() == 0) begin
               check("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("out_data", 32'(out_data), 32'(e.data));
               check("out_last", 32'(out_last), 32'(e.last));
               if (e.cyc >= 0) check("out_cycle", 32'(cyc), 32'(e.cyc));
            end
            if (out_last) done_q.push_back(cyc + 1);
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
         if (done) begin
            if (done_q.size() == 0) check("unexpected_done", 32'(done), 32'd0);
            else check("done_cycle", 32'(cyc), 32'(done_q.pop_front()));
         end
      end
   end

   task automatic do_start(input logic [AW-1:0] b, input logic [DMW-1:0] r, input logic [DMW-1:0] c,
                           input logic t, output int sc);
      @(posedge clock); #1;
      base_addr = b; rows = r; cols = c; transpose = t; start = 1'b1;
      sc = cyc;
      @(posedge clock); #1;
      start = 1'b0;
   endtask

   task automatic push_exp(input logic [DW-1:0] d, input logic l, input int c);
      exp_t x;
      x.data = d; x.last = l; x.cyc = c;
      exp_q.push_back(x);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || done_q.size() != 0 || busy) && n < 300) begin
         @(negedge clock);
         n++;
      end
      check(name, 32'(n < 300), 32'd1);
      repeat (2) @(negedge clock);
   endtask

   task automatic check_outputs_zero();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
   endtask

   initial begin
      logic [DW-1:0] tr_vals [6];
      int hs0;
      int n;
      tr_vals = '{16'h010, 16'h013, 16'h011, 16'h014, 16'h012, 16'h015};

      repeat (2) @(posedge clock);
      #1;
      check_outputs_zero();
      reset = 1'b0;

      // Row-major 2x3 at full rate.
      do_start(10'h010, 6'd2, 6'd3, 1'b0, s);
      for (int i = 0; i < 6; i++) push_exp(16'(16'h010 + i), i == 5, s + 3 + i);
      wait_idle("rowmajor_complete");

      // Transposed 2x3.
      do_start(10'h010, 6'd2, 6'd3, 1'b1, s);
      for (int i = 0; i < 6; i++) push_exp(tr_vals[i], i == 5, s + 3 + i);
      wait_idle("transpose_complete");

      // 4x4 row-major with out_ready low for cycles 4..9 after start.
      do_start(10'h040, 6'd4, 6'd4, 1'b0, s);
      for (int i = 0; i < 16; i++) push_exp(16'(16'h040 + i), i == 15, -1);
      for (int k = 1; k <= 30; k++) begin
         out_ready = !(k >= 4 && k <= 9);
         @(posedge clock); #1;
      end
      out_ready = 1'b1;
      wait_idle("backpressure_complete");

      // Address wrap past the top of the RAM.
      addr_q.push_back(10'h3FE); addr_q.push_back(10'h3FF);
      addr_q.push_back(10'h000); addr_q.push_back(10'h001);
      do_start(10'h3FE, 6'd1, 6'd4, 1'b0, s);
      push_exp(16'h03FE, 1'b0, s + 3);
      push_exp(16'h03FF, 1'b0, s + 4);
      push_exp(16'h0000, 1'b0, s + 5);
      push_exp(16'h0001, 1'b1, s + 6);
      wait_idle("wrap_complete");
      check("wrap_addrs_used", 32'(addr_q.size()), 32'd0);

      // Zero dimension: immediate done, no reads, no output.
      no_reads = 1'b1;
      do_start(10'h020, 6'd0, 6'd5, 1'b0, s);
      done_q.push_back(s + 1);
      wait_idle("zero_complete");
      no_reads = 1'b0;

      // Start while busy must be ignored.
      do_start(10'h080, 6'd3, 6'd3, 1'b0, s);
      for (int i = 0; i < 9; i++) push_exp(16'(16'h080 + i), i == 8, s + 3 + i);
      @(posedge clock); #1;
      base_addr = 10'h200; rows = 6'd1; cols = 6'd1; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      wait_idle("ignore_start_complete");

      // Reset mid-transfer after four handshakes, then a fresh 2x2.
      hs0 = hs_cnt;
      do_start(10'h100, 6'd3, 6'd3, 1'b0, s);
      for (int i = 0; i < 9; i++) push_exp(16'(16'h100 + i), i == 8, -1);
      n = 0;
      while (hs_cnt < hs0 + 4 && n < 100) begin
         @(negedge clock);
         n++;
      end
      check("midreset_reach4", 32'(n < 100), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check_outputs_zero();
      exp_q.delete();
      done_q.delete();
      @(posedge clock);
      @(posedge clock); #1;
      reset = 1'b0;
      do_start(10'h100, 6'd2, 6'd2, 1'b0, s);
      for (int i = 0; i < 4; i++) push_exp(16'(16'h100 + i), i == 3, s + 3 + i);
      wait_idle("after_reset_complete");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
